// File: rtl/rng_state_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rng_state_pkg
// Brief    : Shared FSM state type and width helpers for rng_state_bank.
// Revision : 1.0
// ============================================================================
package rng_state_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    // Channel select keeps at least one bit even for a single channel.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_NUM_BYTES  = 32;
    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_WORD_BYTES = 4;
    localparam int DEF_OFF_W      = $clog2(DEF_NUM_BYTES);
    localparam int DEF_LEN_W      = $clog2(DEF_WORD_BYTES + 1);
    localparam int DEF_CH_W       = clog2_min1(DEF_NUM_CH);

endpackage
`default_nettype wire

// File: rtl/rng_state_byte_array.sv
`default_nettype none
// ============================================================================
// Module   : rng_state_byte_array
// Brief    : One channel's NUM_BYTES x 8 state store, one byte write port,
//            one combinational byte read port, synchronous clear.
// Revision : 1.0
// ============================================================================
module rng_state_byte_array #(
    parameter int NUM_BYTES = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         we,
    input  logic [$clog2(NUM_BYTES)-1:0] waddr,
    input  logic [7:0]                   wdata,
    input  logic [$clog2(NUM_BYTES)-1:0] raddr,
    output logic [7:0]                   rdata
);

    logic [7:0] r_mem [NUM_BYTES];

    // Clear has priority over a coincident byte write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BYTES; i++) r_mem[i] <= 8'h00;
        end else if (clr) begin
            for (int i = 0; i < NUM_BYTES; i++) r_mem[i] <= 8'h00;
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = (32'(raddr) < 32'(NUM_BYTES)) ? r_mem[raddr] : 8'h00;

endmodule
`default_nettype wire

// File: rtl/rng_state_bank.sv
`default_nettype none
// ============================================================================
// Module   : rng_state_bank
// Brief    : NUM_CH byte-addressed RNG state arrays with serial byte-per-cycle
//            read/write requests. Define RNG_STATE_WRAP_EN for modulo offsets.
// Revision : 1.0
// ============================================================================
module rng_state_bank
    import rng_state_pkg::*;
#(
    parameter int NUM_BYTES  = 32,
    parameter int NUM_CH     = 2,
    parameter int WORD_BYTES = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clr,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic                                req_we,
    input  logic [clog2_min1(NUM_CH)-1:0]       req_ch,
    input  logic [$clog2(NUM_BYTES)-1:0]        req_off,
    input  logic [$clog2(WORD_BYTES+1)-1:0]     req_len,
    input  logic [8*WORD_BYTES-1:0]             req_wdata,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [8*WORD_BYTES-1:0]             rsp_rdata,
    output logic                                rsp_err
);

    localparam int OFF_W = $clog2(NUM_BYTES);
    localparam int LEN_W = $clog2(WORD_BYTES + 1);
    localparam int CH_W  = clog2_min1(NUM_CH);
    localparam int DW    = 8 * WORD_BYTES;
    localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(WORD_BYTES);

    state_t             r_state;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic               r_we;
    logic [CH_W-1:0]    r_ch;
    logic               r_ch_bad;
    logic [OFF_W-1:0]   r_off;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic [DW-1:0]      r_wdata;
    logic [DW-1:0]      r_rdata;
    logic               r_err;

    logic               w_accept;
    logic [LEN_W-1:0]   w_len_clamped;
    logic               w_ch_bad;
    logic [31:0]        w_sum;
    logic [OFF_W-1:0]   w_addr;
    logic               w_addr_ok;
    logic               w_byte_ok;
    logic [LEN_W-1:0]   w_cnt_nxt;
    logic [7:0]         w_wbyte;
    logic [7:0]         w_rd_sel;
    logic [7:0]         w_rd [NUM_CH];

    assign w_accept      = (r_state == IDLE) && r_req_ready && req_valid;
    assign w_len_clamped = (req_len > C_MAX_LEN) ? C_MAX_LEN : req_len;
    assign w_ch_bad      = (32'(req_ch) >= 32'(NUM_CH));

    assign w_sum = 32'(r_off) + 32'(r_cnt);
`ifdef RNG_STATE_WRAP_EN
    assign w_addr_ok = (32'(r_off) < 32'(NUM_BYTES));
    assign w_addr    = OFF_W'(w_sum % 32'(NUM_BYTES));
`else
    assign w_addr_ok = (w_sum < 32'(NUM_BYTES));
    assign w_addr    = OFF_W'(w_sum);
`endif

    assign w_byte_ok = !r_ch_bad && w_addr_ok;
    assign w_cnt_nxt = r_cnt + LEN_W'(1);
    assign w_wbyte   = r_wdata[8*r_cnt +: 8];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic w_we_ch;
        assign w_we_ch = (r_state == XFER) && r_we && w_byte_ok && (r_ch == CH_W'(k));

        rng_state_byte_array #(
            .NUM_BYTES (NUM_BYTES)
        ) u_array (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .we    (w_we_ch),
            .waddr (w_addr),
            .wdata (w_wbyte),
            .raddr (w_addr),
            .rdata (w_rd[k])
        );
    end

    always_comb begin
        w_rd_sel = 8'h00;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_ch == CH_W'(k)) w_rd_sel = w_rd[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_we        <= 1'b0;
            r_ch        <= '0;
            r_ch_bad    <= 1'b0;
            r_off       <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_we        <= req_we;
                        r_ch        <= req_ch;
                        r_ch_bad    <= w_ch_bad;
                        r_off       <= req_off;
                        r_len       <= w_len_clamped;
                        r_wdata     <= req_wdata;
                        r_cnt       <= '0;
                        r_rdata     <= '0;
                        r_err       <= w_ch_bad;
                        r_req_ready <= 1'b0;
                        if (w_len_clamped != '0) begin
                            r_state <= XFER;
                        end else begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                        end
                    end
                end
                XFER: begin
                    // Skipped bytes leave the accumulator at its cleared zero.
                    if (!r_we && w_byte_ok) r_rdata[8*r_cnt +: 8] <= w_rd_sel;
                    if (!w_byte_ok) r_err <= 1'b1;
                    r_cnt <= w_cnt_nxt;
                    if (w_cnt_nxt == r_len) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
`default_nettype wire
